// File: rtl/pe_bram_responder.sv
// BRAM responder for the PE controller: operand/result word memory, host access port and run control.
// Optional BUSY watchdog is enabled by defining PE_BRAM_RESPONDER_WDOG_EN.
module pe_bram_responder #(
  parameter int          DEPTH_LOG2  = 8,
  parameter logic [31:0] RESULT_ADDR = 32'h200,
  parameter int          WDOG_CYCLES = 4096
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [31:0]           BRAM_ADDR,
  input  logic [31:0]           BRAM_WRDATA,
  input  logic [3:0]            BRAM_WE,
  output logic [31:0]           BRAM_RDDATA,
  input  logic [DEPTH_LOG2-1:0] host_addr,
  input  logic [31:0]           host_wdata,
  input  logic                  host_we,
  input  logic                  host_re,
  output logic                  host_ready,
  output logic [31:0]           host_rdata,
  output logic                  host_rvalid,
  input  logic                  start_req,
  output logic                  pe_start,
  input  logic                  pe_done,
  output logic                  result_valid,
  output logic [31:0]           result_data,
  input  logic                  result_ack,
  output logic                  addr_err,
  output logic                  seq_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_RESULT} state_e;

  state_e state_q, state_d;

  logic [31:0] mem [DEPTH];

  logic [31:0] rd_q, rd_d;
  logic [31:0] result_data_q, result_data_d;
  logic        result_valid_q, result_valid_d;
  logic        host_rvalid_q, host_rvalid_d;
  logic        addr_err_q, addr_err_d;
  logic        seq_err_q, seq_err_d;

`ifdef PE_BRAM_RESPONDER_WDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);
  logic [15:0] wdog_q, wdog_d;
`endif

  logic                  pe_owner;
  logic                  pe_in_range;
  logic [DEPTH_LOG2-1:0] pe_idx;
  logic [31:0]           pe_old;
  logic [31:0]           pe_merged;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_widx;
  logic [31:0]           mem_wword;

  assign pe_owner    = (state_q == S_START) || (state_q == S_BUSY);
  assign pe_in_range = (BRAM_ADDR[31:DEPTH_LOG2+2] == '0) && (BRAM_ADDR[1:0] == 2'b00);
  assign pe_idx      = BRAM_ADDR[DEPTH_LOG2+1:2];
  assign pe_old      = mem[pe_idx];

  always_comb begin
    pe_merged = pe_old;
    for (int i = 0; i < 4; i++) begin
      if (BRAM_WE[i]) pe_merged[8*i +: 8] = BRAM_WRDATA[8*i +: 8];
    end
  end

  always_comb begin
    state_d        = state_q;
    rd_d           = '0;
    host_rvalid_d  = 1'b0;
    result_valid_d = result_valid_q;
    result_data_d  = result_data_q;
    addr_err_d     = addr_err_q;
    seq_err_d      = seq_err_q;
    mem_we         = 1'b0;
    mem_widx       = host_addr;
    mem_wword      = host_wdata;
`ifdef PE_BRAM_RESPONDER_WDOG_EN
    wdog_d         = wdog_q;
`endif

    // Read-first: rd_q always samples the pre-write word of whoever owns the port.
    if (pe_owner) rd_d = pe_in_range ? pe_old : '0;
    else          rd_d = mem[host_addr];

    unique case (state_q)
      S_IDLE: begin
        if (host_we) begin
          mem_we = 1'b1;
        end else if (host_re) begin
          host_rvalid_d = 1'b1;
        end
        if (start_req) state_d = S_START;
      end
      S_START: begin
        addr_err_d     = 1'b0;
        seq_err_d      = 1'b0;
        result_valid_d = 1'b0;
        state_d        = S_BUSY;
`ifdef PE_BRAM_RESPONDER_WDOG_EN
        wdog_d         = '0;
`endif
      end
      S_BUSY: begin
        if (!pe_in_range) addr_err_d = 1'b1;
        if (pe_in_range && (BRAM_WE != 4'b0000)) begin
          mem_we    = 1'b1;
          mem_widx  = pe_idx;
          mem_wword = pe_merged;
        end
        if ((BRAM_WE != 4'b0000) && (BRAM_ADDR == RESULT_ADDR)) begin
          result_data_d  = pe_merged;
          result_valid_d = 1'b1;
        end
        // A capture in this same cycle already shows up in result_valid_d.
        if (pe_done) begin
          if (result_valid_d) begin
            state_d = S_RESULT;
          end else begin
            seq_err_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
`ifdef PE_BRAM_RESPONDER_WDOG_EN
        else if (wdog_q == WDOG_LAST) begin
          seq_err_d      = 1'b1;
          result_valid_d = 1'b0;
          state_d        = S_IDLE;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
`endif
      end
      S_RESULT: begin
        if (host_re) host_rvalid_d = 1'b1;
        if (result_ack && result_valid_q) begin
          result_valid_d = 1'b0;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q        <= S_IDLE;
      rd_q           <= '0;
      host_rvalid_q  <= 1'b0;
      result_valid_q <= 1'b0;
      result_data_q  <= '0;
      addr_err_q     <= 1'b0;
      seq_err_q      <= 1'b0;
`ifdef PE_BRAM_RESPONDER_WDOG_EN
      wdog_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      rd_q           <= rd_d;
      host_rvalid_q  <= host_rvalid_d;
      result_valid_q <= result_valid_d;
      result_data_q  <= result_data_d;
      addr_err_q     <= addr_err_d;
      seq_err_q      <= seq_err_d;
`ifdef PE_BRAM_RESPONDER_WDOG_EN
      wdog_q         <= wdog_d;
`endif
    end
  end

  // Memory contents survive reset; only writes are suppressed while it is held.
  always_ff @(posedge aclk) begin
    if (aresetn && mem_we) mem[mem_widx] <= mem_wword;
  end

  assign BRAM_RDDATA  = rd_q;
  assign host_rdata   = rd_q;
  assign host_rvalid  = host_rvalid_q;
  assign host_ready   = (state_q == S_IDLE) || (state_q == S_RESULT);
  assign pe_start     = (state_q == S_START);
  assign result_valid = result_valid_q;
  assign result_data  = result_data_q;
  assign addr_err     = addr_err_q;
  assign seq_err      = seq_err_q;

endmodule

// File: tb/tb_pe_bram_responder.sv
// Self-checking bench for pe_bram_responder: host vector table plus hand-written PE run sequences.
module tb_pe_bram_responder;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] BRAM_ADDR, BRAM_WRDATA, BRAM_RDDATA;
  logic [3:0]  BRAM_WE;
  logic [7:0]  host_addr;
  logic [31:0] host_wdata, host_rdata, result_data;
  logic        host_we, host_re, host_ready, host_rvalid;
  logic        start_req, pe_start, pe_done, result_valid, result_ack, addr_err, seq_err;

  pe_bram_responder #(.DEPTH_LOG2(8), .RESULT_ADDR(32'h200), .WDOG_CYCLES(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_WRDATA(BRAM_WRDATA), .BRAM_WE(BRAM_WE), .BRAM_RDDATA(BRAM_RDDATA),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_we(host_we), .host_re(host_re),
    .host_ready(host_ready), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .start_req(start_req), .pe_start(pe_start), .pe_done(pe_done),
    .result_valid(result_valid), .result_data(result_data), .result_ack(result_ack),
    .addr_err(addr_err), .seq_err(seq_err)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic        hostWe;
    logic        hostRe;
    logic [7:0]  hostAddr;
    logic [31:0] hostWdata;
    logic [31:0] expData;
    logic        expReady;
  } vec_t;

  vec_t        vecs[40];
  logic [31:0] hostQ[$];
  logic [31:0] peQ[$];
  int          vecCount = 0;
  int          missCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // One host-side cycle: expected read data is queued when the read is issued and retired on host_rvalid.
  task automatic applyStimulus(input vec_t v);
    logic expValid;
    logic [31:0] e;
    host_we    = v.hostWe;
    host_re    = v.hostRe;
    host_addr  = v.hostAddr;
    host_wdata = v.hostWdata;
    checkOutput("host_ready", {31'd0, host_ready}, {31'd0, v.expReady});
    expValid = v.hostRe && !v.hostWe && v.expReady;
    if (expValid) hostQ.push_back(v.expData);
    tick();
    host_we = 1'b0;
    host_re = 1'b0;
    checkOutput("host_rvalid", {31'd0, host_rvalid}, {31'd0, expValid});
    if (host_rvalid) begin
      if (hostQ.size() == 0) begin
        checkOutput("host_q_empty", 32'd1, 32'd0);
      end else begin
        e = hostQ.pop_front();
        checkOutput("host_rdata", host_rdata, e);
        checkOutput("rd_alias", BRAM_RDDATA, e);
      end
    end
  endtask

  task automatic peAccess(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wdata,
                          input logic [31:0] expRd);
    logic [31:0] e;
    BRAM_ADDR   = addr;
    BRAM_WE     = we;
    BRAM_WRDATA = wdata;
    peQ.push_back(expRd);
    tick();
    BRAM_WE   = 4'b0000;
    BRAM_ADDR = 32'h0;
    e = peQ.pop_front();
    checkOutput("bram_rddata", BRAM_RDDATA, e);
  endtask

  function automatic vec_t hv(input logic we, input logic re, input logic [7:0] a,
                              input logic [31:0] wd, input logic [31:0] ed, input logic rdy);
    vec_t v;
    v.hostWe = we; v.hostRe = re; v.hostAddr = a; v.hostWdata = wd; v.expData = ed; v.expReady = rdy;
    return v;
  endfunction

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkOutput(name, {31'd0, act}, {31'd0, exp});
  endtask

  initial begin
    for (int k = 0; k < 32; k++) vecs[k] = hv(1'b1, 1'b0, 8'(32 + k), 32'(k + 1), 32'h0, 1'b1);
    vecs[32] = hv(1'b1, 1'b0, 8'd10,  32'h1122_3344, 32'h0, 1'b1);
    vecs[33] = hv(1'b1, 1'b0, 8'd128, 32'hDEAD_0000, 32'h0, 1'b1);
    vecs[34] = hv(1'b1, 1'b0, 8'd64,  32'h0000_0064, 32'h0, 1'b1);
    vecs[35] = hv(1'b0, 1'b1, 8'd40,  32'h0, 32'd9, 1'b1);
    vecs[36] = hv(1'b0, 1'b1, 8'd33,  32'h0, 32'd2, 1'b1);
    vecs[37] = hv(1'b1, 1'b1, 8'd63,  32'h0000_CAFE, 32'h0, 1'b1);
    vecs[38] = hv(1'b0, 1'b1, 8'd63,  32'h0, 32'h0000_CAFE, 1'b1);
    vecs[39] = hv(1'b0, 1'b1, 8'd10,  32'h0, 32'h1122_3344, 1'b1);

    aresetn = 1'b0; BRAM_ADDR = 32'h0; BRAM_WRDATA = 32'h0; BRAM_WE = 4'h0;
    host_addr = 8'h0; host_wdata = 32'h0; host_we = 1'b0; host_re = 1'b0;
    start_req = 1'b0; pe_done = 1'b0; result_ack = 1'b0;
    tick(); tick();
    checkBit("rst_pe_start", pe_start, 1'b0);
    checkBit("rst_host_rvalid", host_rvalid, 1'b0);
    checkBit("rst_result_valid", result_valid, 1'b0);
    checkBit("rst_addr_err", addr_err, 1'b0);
    checkBit("rst_seq_err", seq_err, 1'b0);
    checkBit("rst_host_ready", host_ready, 1'b1);
    checkOutput("rst_result_data", result_data, 32'h0);
    checkOutput("rst_rddata", BRAM_RDDATA, 32'h0);
    aresetn = 1'b1;
    tick();

    for (int i = 0; i < 40; i++) applyStimulus(vecs[i]);

    // PE write outside BUSY must not touch memory
    BRAM_ADDR = 32'h100; BRAM_WE = 4'hF; BRAM_WRDATA = 32'hFFFF_FFFF;
    tick();
    BRAM_WE = 4'h0; BRAM_ADDR = 32'h0;
    applyStimulus(hv(1'b0, 1'b1, 8'd64, 32'h0, 32'h0000_0064, 1'b1));

    // Run 1: start taken together with a host read, byte writes, result capture
    start_req = 1'b1;
    applyStimulus(hv(1'b0, 1'b1, 8'd40, 32'h0, 32'd9, 1'b1));
    start_req = 1'b0;
    checkBit("r1_pe_start_hi", pe_start, 1'b1);
    checkBit("r1_ready_start", host_ready, 1'b0);
    tick();
    checkBit("r1_pe_start_lo", pe_start, 1'b0);
    checkBit("r1_rv_cleared", result_valid, 1'b0);
    applyStimulus(hv(1'b1, 1'b0, 8'd40, 32'h77, 32'h0, 1'b0));
    applyStimulus(hv(1'b0, 1'b1, 8'd33, 32'h0, 32'h0, 1'b0));
    peAccess(32'h84, 4'h0, 32'h0, 32'd2);
    peAccess(32'h28, 4'h0, 32'h0, 32'h1122_3344);
    peAccess(32'h28, 4'b0011, 32'hAABB_CCDD, 32'h1122_3344);
    peAccess(32'h28, 4'h0, 32'h0, 32'h1122_CCDD);
    checkBit("r1_rv_before", result_valid, 1'b0);
    peAccess(32'h200, 4'hF, 32'h0000_0550, 32'hDEAD_0000);
    checkBit("r1_rv_after", result_valid, 1'b1);
    checkOutput("r1_result_data", result_data, 32'h0000_0550);
    peAccess(32'h200, 4'h0, 32'h0, 32'h0000_0550);
    checkBit("r1_ready_busy", host_ready, 1'b0);
    pe_done = 1'b1; tick(); pe_done = 1'b0;
    checkBit("r1_ready_result", host_ready, 1'b1);
    checkBit("r1_rv_result", result_valid, 1'b1);
    checkBit("r1_seq_err", seq_err, 1'b0);
    checkBit("r1_addr_err", addr_err, 1'b0);
    start_req = 1'b1;
    applyStimulus(hv(1'b1, 1'b0, 8'd50, 32'h1234, 32'h0, 1'b1));
    start_req = 1'b0;
    checkBit("r1_start_ignored", pe_start, 1'b0);
    applyStimulus(hv(1'b0, 1'b1, 8'd50, 32'h0, 32'd19, 1'b1));
    result_ack = 1'b1; tick(); result_ack = 1'b0;
    checkBit("r1_rv_acked", result_valid, 1'b0);
    checkOutput("r1_result_held", result_data, 32'h0000_0550);
    applyStimulus(hv(1'b1, 1'b0, 8'd50, 32'h1234, 32'h0, 1'b1));
    applyStimulus(hv(1'b0, 1'b1, 8'd50, 32'h0, 32'h1234, 1'b1));
    applyStimulus(hv(1'b0, 1'b1, 8'd40, 32'h0, 32'd9, 1'b1));

    // Run 2: out-of-range accesses and pe_done with no result write
    start_req = 1'b1; tick(); start_req = 1'b0;
    checkBit("r2_pe_start", pe_start, 1'b1);
    tick();
    peAccess(32'h400, 4'h0, 32'h0, 32'h0);
    checkBit("r2_addr_err", addr_err, 1'b1);
    peAccess(32'h86, 4'h0, 32'h0, 32'h0);
    peAccess(32'h484, 4'hF, 32'h99, 32'h0);
    pe_done = 1'b1; tick(); pe_done = 1'b0;
    checkBit("r2_seq_err", seq_err, 1'b1);
    checkBit("r2_rv", result_valid, 1'b0);
    checkBit("r2_addr_sticky", addr_err, 1'b1);
    applyStimulus(hv(1'b0, 1'b1, 8'd33, 32'h0, 32'd2, 1'b1));

    // Run 3: flags cleared by the next start, then reset mid-BUSY
    start_req = 1'b1; tick(); start_req = 1'b0;
    tick();
    checkBit("r3_addr_clr", addr_err, 1'b0);
    checkBit("r3_seq_clr", seq_err, 1'b0);
    peAccess(32'h84, 4'h0, 32'h0, 32'd2);
    aresetn = 1'b0; tick(); aresetn = 1'b1;
    checkBit("r3_pe_start", pe_start, 1'b0);
    checkBit("r3_rvalid", host_rvalid, 1'b0);
    checkBit("r3_result_valid", result_valid, 1'b0);
    checkOutput("r3_result_data", result_data, 32'h0);
    checkOutput("r3_rddata", BRAM_RDDATA, 32'h0);
    applyStimulus(hv(1'b0, 1'b1, 8'd10, 32'h0, 32'h1122_CCDD, 1'b1));
    applyStimulus(hv(1'b0, 1'b1, 8'd128, 32'h0, 32'h0000_0550, 1'b1));
    applyStimulus(hv(1'b0, 1'b1, 8'd64, 32'h0, 32'h0000_0064, 1'b1));

`ifdef PE_BRAM_RESPONDER_WDOG_EN
    start_req = 1'b1; tick(); start_req = 1'b0;
    for (int c = 0; c < 16; c++) tick();
    checkBit("wdog_not_yet", seq_err, 1'b0);
    tick();
    checkBit("wdog_seq_err", seq_err, 1'b1);
    checkBit("wdog_idle", host_ready, 1'b1);
`endif

    checkOutput("host_q_drained", 32'(hostQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
